dma_xfer_engine: RTL and testbench

DMA_XFER_ENGINE -- requirements
Module: dma_xfer_engine

---
 rtl/dma_pkg.sv | 31 +++
 rtl/dma_fifo.sv | 59 +++++
 rtl/dma_xfer_engine.sv | 202 ++++++++++++++++++++
 tb/tb_dma_xfer_engine.sv | 453 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dma_pkg.sv
// dma_pkg: shared state encoding, error codes and
// burst decode for the DMA transfer engine.
package dma_pkg;

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_RD_REQ  = 4'd1,
    S_RD_WAIT = 4'd2,
    S_WR_REQ  = 4'd3,
    S_DONE    = 4'd4,
    S_ERR     = 4'd5
  } state_t;

  localparam logic [7:0] ERR_BUS     = 8'h01;
  localparam logic [7:0] ERR_TIMEOUT = 8'h02;
  localparam logic [7:0] ERR_ALIGN   = 8'h03;

  function automatic logic [3:0] burst_len(
    input logic [1:0] bs
  );
    logic [3:0] n;
    unique case (bs)
      2'd0:    n = 4'd1;
      2'd1:    n = 4'd2;
      2'd2:    n = 4'd4;
      default: n = 4'd8;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/dma_fifo.sv
// dma_fifo: 32-bit word buffer between the read and
// write phases of a burst.
module dma_fifo #(
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH),
  localparam int LW    = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   level
);

  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = level == LW'(DEPTH);
  assign empty   = level == '0;
  assign rdata   = mem[rd_ptr];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (do_push && !flush)
      mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push)
        wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)
        rd_ptr <= rd_ptr + AW'(1);
      unique case ({do_push, do_pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/dma_xfer_engine.sv
// dma_xfer_engine: single-channel copy engine; each burst
// is read into the FIFO, then drained to the destination.
module dma_xfer_engine
  import dma_pkg::*;
#(
  parameter int FIFO_DEPTH  = 8,
  parameter int TIMEOUT_CYC = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [14:0] word_count,
  input  logic        io_mem,
  input  logic [1:0]  burst_size,
  input  logic [31:0] src_addr,
  input  logic [31:0] dst_addr,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  input  logic        mem_err,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [3:0]  state,
  output logic [7:0]  fifo_level,
  output logic [31:0] xfer_count,
  output logic [7:0]  err_code,
  output logic [15:0] err_offset
);

  localparam int LW = $clog2(FIFO_DEPTH) + 1;

  state_t        st;
  logic [31:0]   src;
  logic [31:0]   dst;
  logic [14:0]   wc;
  logic          io;
  logic [1:0]    bsz;
  logic [3:0]    burst_left;
  logic [15:0]   rd_cnt;
  logic [31:0]   wait_cnt;
  logic          armed;
  logic [31:0]   fifo_head;
  logic [LW-1:0] lvl;
  logic          fifo_full;
  logic          fifo_empty;
  logic          push;
  logic          pop;
  logic          flush;
  logic          rd_ev;
  logic          wr_ev;
  logic          tmo;
  logic          busy_st;

  // Burst = min(decoded burst, words left, FIFO depth);
  // the FIFO is always empty when a burst begins.
  function automatic logic [3:0] next_burst(
    input logic [1:0]  bs,
    input logic [15:0] rem
  );
    logic [3:0] n;
    n = burst_len(bs);
    if (rem < 16'(n))
      n = rem[3:0];
    if (FIFO_DEPTH < int'(n))
      n = 4'(FIFO_DEPTH);
    return n;
  endfunction

  assign busy_st = st inside {S_RD_REQ, S_RD_WAIT, S_WR_REQ};
  assign rd_ev   = (st == S_RD_WAIT) && mem_rvalid;
  assign wr_ev   = (st == S_WR_REQ) && mem_gnt;
  assign tmo     = busy_st && !rd_ev && !wr_ev &&
                   !((st == S_RD_REQ) && mem_gnt) &&
                   (wait_cnt == 32'(TIMEOUT_CYC - 1));
  assign flush   = tmo || ((rd_ev || wr_ev) && mem_err);
  assign push    = rd_ev && !mem_err && !fifo_full;
  assign pop     = wr_ev && !mem_err && !fifo_empty;

  dma_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .flush (flush),
    .wdata (mem_rdata),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (lvl)
  );

  assign state      = st;
  assign busy       = busy_st;
  assign done       = st == S_DONE;
  assign error      = st == S_ERR;
  assign mem_req    = (st == S_RD_REQ) || (st == S_WR_REQ);
  assign mem_we     = st == S_WR_REQ;
  assign mem_addr   = (st == S_RD_REQ) ? src :
                      (st == S_WR_REQ) ? dst : '0;
  assign mem_wdata  = mem_we ? fifo_head : '0;
  assign fifo_level = 8'(lvl);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st         <= S_IDLE;
      src        <= '0;
      dst        <= '0;
      wc         <= '0;
      io         <= 1'b0;
      bsz        <= '0;
      burst_left <= '0;
      rd_cnt     <= '0;
      wait_cnt   <= '0;
      armed      <= 1'b0;
      xfer_count <= '0;
      err_code   <= '0;
      err_offset <= '0;
    end else begin
      armed    <= 1'b1;
      wait_cnt <= busy_st ? wait_cnt + 32'd1 : '0;
      if (tmo) begin
        st         <= S_ERR;
        err_code   <= ERR_TIMEOUT;
        err_offset <= (st == S_WR_REQ) ? xfer_count[15:0]
                                       : rd_cnt;
      end else begin
        unique case (st)
          S_IDLE: if (start && armed) begin
            src        <= src_addr;
            dst        <= dst_addr;
            wc         <= word_count;
            io         <= io_mem;
            bsz        <= burst_size;
            xfer_count <= '0;
            rd_cnt     <= '0;
            err_code   <= '0;
            err_offset <= '0;
            wait_cnt   <= '0;
            if (|src_addr[1:0] || |dst_addr[1:0]) begin
              st       <= S_ERR;
              err_code <= ERR_ALIGN;
            end else if (word_count == '0) begin
              st <= S_DONE;
            end else begin
              st         <= S_RD_REQ;
              burst_left <= next_burst(burst_size,
                                       {1'b0, word_count});
            end
          end
          S_RD_REQ: if (mem_gnt) begin
            st       <= S_RD_WAIT;
            wait_cnt <= '0;
          end
          S_RD_WAIT: if (mem_rvalid) begin
            wait_cnt <= '0;
            if (mem_err) begin
              st         <= S_ERR;
              err_code   <= ERR_BUS;
              err_offset <= rd_cnt;
            end else begin
              src        <= src + 32'd4;
              rd_cnt     <= rd_cnt + 16'd1;
              burst_left <= burst_left - 4'd1;
              st <= (burst_left == 4'd1) ? S_WR_REQ
                                         : S_RD_REQ;
            end
          end
          S_WR_REQ: if (mem_gnt) begin
            wait_cnt <= '0;
            if (mem_err) begin
              st         <= S_ERR;
              err_code   <= ERR_BUS;
              err_offset <= xfer_count[15:0];
            end else begin
              xfer_count <= xfer_count + 32'd1;
              if (!io)
                dst <= dst + 32'd4;
              if (lvl == LW'(1)) begin
                if (xfer_count + 32'd1 == {17'd0, wc}) begin
                  st <= S_DONE;
                end else begin
                  st         <= S_RD_REQ;
                  burst_left <= next_burst(bsz,
                                  {1'b0, wc} - rd_cnt);
                end
              end
            end
          end
          S_DONE:  st <= S_IDLE;
          S_ERR:   st <= S_IDLE;
          default: st <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_dma_xfer_engine.sv
// tb_dma_xfer_engine: randomized memory responder plus a
// burst-level reference model of the expected bus traffic.
module tb_dma_xfer_engine;

  localparam int DEPTH = 4;
  localparam int TMO   = 256;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
  } op_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [14:0] word_count = '0;
  logic        io_mem = 1'b0;
  logic [1:0]  burst_size = '0;
  logic [31:0] src_addr = '0;
  logic [31:0] dst_addr = '0;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_gnt = 1'b0;
  logic        mem_rvalid = 1'b0;
  logic        mem_err = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        busy, done, error;
  logic [3:0]  state;
  logic [7:0]  fifo_level;
  logic [31:0] xfer_count;
  logic [7:0]  err_code;
  logic [15:0] err_offset;

  int checks = 0;
  int errors = 0;

  op_t act_q[$];
  op_t exp_q[$];
  int  done_cnt, err_cnt, req_cyc, viol;
  int  rd_idx, wr_idx, inj_rd, inj_wr;
  int  gmax, rmax;
  bit  gnt_block;
  bit  pend, hold_v, h_we;
  logic [31:0] pend_addr, h_addr, h_data;
  logic [7:0]  end_lvl;
  logic        end_req;

  dma_xfer_engine #(
    .FIFO_DEPTH  (DEPTH),
    .TIMEOUT_CYC (TMO)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .word_count (word_count),
    .io_mem     (io_mem),
    .burst_size (burst_size),
    .src_addr   (src_addr),
    .dst_addr   (dst_addr),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_gnt    (mem_gnt),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata),
    .mem_err    (mem_err),
    .busy       (busy),
    .done       (done),
    .error      (error),
    .state      (state),
    .fifo_level (fifo_level),
    .xfer_count (xfer_count),
    .err_code   (err_code),
    .err_offset (err_offset)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] fdata(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  // Memory: grants and read returns with random latency,
  // drives responses on the falling edge.
  always @(negedge clk) begin
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b0;
    mem_err    = 1'b0;
    if (!rst_n) begin
      pend   = 1'b0;
      hold_v = 1'b0;
    end else begin
      if (done) done_cnt++;
      if (error) err_cnt++;
      if (mem_req) req_cyc++;
      if (mem_req && hold_v &&
          (mem_addr !== h_addr || mem_we !== h_we ||
           (mem_we && mem_wdata !== h_data)))
        viol++;
      if (mem_req && pend) viol++;
      if (pend) begin
        if ($urandom_range(0, rmax) == 0) begin
          mem_rvalid = 1'b1;
          mem_rdata  = fdata(pend_addr);
          if (rd_idx == inj_rd) mem_err = 1'b1;
          rd_idx++;
          pend = 1'b0;
        end
      end else if (mem_req && !gnt_block &&
                   $urandom_range(0, gmax) == 0) begin
        mem_gnt = 1'b1;
        if (mem_we) begin
          if (wr_idx == inj_wr) mem_err = 1'b1;
          else act_q.push_back({1'b1, mem_addr, mem_wdata});
          wr_idx++;
        end else begin
          act_q.push_back({1'b0, mem_addr, fdata(mem_addr)});
          pend      = 1'b1;
          pend_addr = mem_addr;
        end
      end
      hold_v = mem_req && !mem_gnt;
      h_addr = mem_addr;
      h_we   = mem_we;
      h_data = mem_wdata;
    end
  end

  task automatic build_exp(input logic [31:0] s, d,
                           input int wc, input bit io,
                           input int bs);
    int rem, k, b;
    exp_q.delete();
    rem = wc;
    k   = 0;
    while (rem > 0) begin
      b = 1 << bs;
      if (rem < b) b = rem;
      if (DEPTH < b) b = DEPTH;
      for (int i = 0; i < b; i++)
        exp_q.push_back({1'b0, s + 32'(4 * (k + i)),
                         fdata(s + 32'(4 * (k + i)))});
      for (int i = 0; i < b; i++)
        exp_q.push_back({1'b1,
                         io ? d : d + 32'(4 * (k + i)),
                         fdata(s + 32'(4 * (k + i)))});
      k   += b;
      rem -= b;
    end
  endtask

  function automatic int diff_ops();
    int n;
    n = 0;
    if (act_q.size() != exp_q.size()) n++;
    for (int i = 0; i < act_q.size() && i < exp_q.size(); i++)
      if (act_q[i] !== exp_q[i]) n++;
    return n;
  endfunction

  task automatic run_xfer(input logic [31:0] s, d,
                          input int wc, input bit io,
                          input int bs, input int budget,
                          input int restart_at,
                          output int cyc, output bit fin);
    act_q.delete();
    done_cnt = 0; err_cnt = 0; req_cyc = 0;
    rd_idx = 0; wr_idx = 0;
    @(negedge clk);
    src_addr = s; dst_addr = d; word_count = wc[14:0];
    io_mem = io; burst_size = bs[1:0]; start = 1'b1;
    fin = 1'b0;
    cyc = 0;
    while (!fin && cyc < budget) begin
      @(negedge clk);
      start = 1'b0;
      cyc++;
      if (cyc == restart_at) begin
        src_addr = 32'h0000_8000; dst_addr = 32'h0000_9000;
        word_count = 15'd2; start = 1'b1;
      end
      if (done || error) begin
        fin = 1'b1;
        end_lvl = fifo_level;
        end_req = mem_req;
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    checks++;
    if ({mem_req, mem_we, busy, done, error, state, fifo_level,
         xfer_count, err_code, err_offset, mem_addr,
         mem_wdata} !== '0) begin
      errors++;
      $display("FAIL reset_hold: outputs not all zero, state=%0d xfer=%0d",
               state, xfer_count);
    end
    rst_n = 1'b1;
    #1;
    checks++;
    if (state !== 4'd0 || busy !== 1'b0 || mem_req !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: state=%0d busy=%b req=%b want 0 0 0",
               state, busy, mem_req);
    end
  endtask

  task automatic test_basic;
    int cyc; bit fin; int n;
    gmax = 0; rmax = 0;
    build_exp(32'h1000, 32'h2000, 5, 1'b0, 2);
    run_xfer(32'h1000, 32'h2000, 5, 1'b0, 2, 300, -1, cyc, fin);
    n = diff_ops();
    checks++;
    if (!fin || n != 0) begin
      errors++;
      $display("FAIL basic_ops: fin=%b diffs=%0d got %0d ops want %0d",
               fin, n, act_q.size(), exp_q.size());
    end
    checks++;
    if (done_cnt != 1 || err_cnt != 0) begin
      errors++;
      $display("FAIL basic_pulse: done=%0d err=%0d want 1 0",
               done_cnt, err_cnt);
    end
    checks++;
    if (xfer_count !== 32'd5 || state !== 4'd0) begin
      errors++;
      $display("FAIL basic_count: xfer=%0d state=%0d want 5 0",
               xfer_count, state);
    end
  endtask

  task automatic test_io_mem;
    int cyc; bit fin; int n;
    gmax = 1; rmax = 1;
    build_exp(32'h4000, 32'h3000, 3, 1'b1, 3);
    run_xfer(32'h4000, 32'h3000, 3, 1'b1, 3, 300, -1, cyc, fin);
    n = diff_ops();
    checks++;
    if (!fin || n != 0 || xfer_count !== 32'd3) begin
      errors++;
      $display("FAIL io_mem: fin=%b diffs=%0d xfer=%0d want 0 diffs 3",
               fin, n, xfer_count);
    end
  endtask

  task automatic test_align;
    int cyc; bit fin;
    run_xfer(32'h1002, 32'h2000, 4, 1'b0, 1, 20, -1, cyc, fin);
    checks++;
    if (req_cyc != 0 || err_cnt != 1 || cyc != 1) begin
      errors++;
      $display("FAIL align_src: req=%0d errp=%0d cyc=%0d want 0 1 1",
               req_cyc, err_cnt, cyc);
    end
    checks++;
    if (err_code !== 8'h03 || err_offset !== 16'd0) begin
      errors++;
      $display("FAIL align_code: code=%h off=%0d want 03 0",
               err_code, err_offset);
    end
    run_xfer(32'h1000, 32'h2001, 4, 1'b0, 1, 20, -1, cyc, fin);
    checks++;
    if (req_cyc != 0 || err_code !== 8'h03 || done_cnt != 0) begin
      errors++;
      $display("FAIL align_dst: req=%0d code=%h done=%0d want 0 03 0",
               req_cyc, err_code, done_cnt);
    end
  endtask

  task automatic test_bus_err;
    int cyc; bit fin;
    gmax = 0; rmax = 0;
    inj_rd = 2;
    run_xfer(32'h5000, 32'h6000, 4, 1'b0, 2, 200, -1, cyc, fin);
    inj_rd = -1;
    checks++;
    if (err_code !== 8'h01 || err_offset !== 16'd2 || err_cnt != 1) begin
      errors++;
      $display("FAIL rd_err: code=%h off=%0d errp=%0d want 01 2 1",
               err_code, err_offset, err_cnt);
    end
    checks++;
    if (end_lvl !== 8'd0 || end_req !== 1'b0 || done_cnt != 0) begin
      errors++;
      $display("FAIL rd_err_flush: lvl=%0d req=%b done=%0d want 0 0 0",
               end_lvl, end_req, done_cnt);
    end
    inj_wr = 1;
    run_xfer(32'h5000, 32'h6000, 6, 1'b0, 3, 200, -1, cyc, fin);
    inj_wr = -1;
    checks++;
    if (err_code !== 8'h01 || err_offset !== 16'd1 ||
        xfer_count !== 32'd1 || end_lvl !== 8'd0) begin
      errors++;
      $display("FAIL wr_err: code=%h off=%0d xfer=%0d lvl=%0d want 01 1 1 0",
               err_code, err_offset, xfer_count, end_lvl);
    end
  endtask

  task automatic test_timeout;
    int cyc; bit fin;
    gnt_block = 1'b1;
    run_xfer(32'h7000, 32'h7100, 2, 1'b0, 0, 400, -1, cyc, fin);
    gnt_block = 1'b0;
    checks++;
    if (!fin || err_code !== 8'h02 || err_offset !== 16'd0) begin
      errors++;
      $display("FAIL timeout: fin=%b code=%h off=%0d want 1 02 0",
               fin, err_code, err_offset);
    end
    checks++;
    if (req_cyc != TMO) begin
      errors++;
      $display("FAIL timeout_len: req cycles=%0d want %0d",
               req_cyc, TMO);
    end
    run_xfer(32'h7000, 32'h7100, 0, 1'b0, 0, 20, -1, cyc, fin);
    checks++;
    if (cyc != 1 || done_cnt != 1 || req_cyc != 0 ||
        xfer_count !== 32'd0) begin
      errors++;
      $display("FAIL zero_wc: cyc=%0d done=%0d req=%0d xfer=%0d want 1 1 0 0",
               cyc, done_cnt, req_cyc, xfer_count);
    end
  endtask

  task automatic test_busy_ignore;
    int cyc; bit fin; int n;
    gmax = 2; rmax = 2;
    build_exp(32'h0A00, 32'h0B00, 6, 1'b0, 1);
    run_xfer(32'h0A00, 32'h0B00, 6, 1'b0, 1, 500, 3, cyc, fin);
    n = diff_ops();
    checks++;
    if (!fin || n != 0 || done_cnt != 1 || xfer_count !== 32'd6) begin
      errors++;
      $display("FAIL busy_ignore: fin=%b diffs=%0d done=%0d xfer=%0d",
               fin, n, done_cnt, xfer_count);
    end
  endtask

  task automatic test_random;
    int cyc; bit fin; int n, wc, bs;
    bit io;
    logic [31:0] s, d;
    for (int t = 0; t < 14; t++) begin
      gmax = $urandom_range(0, 3);
      rmax = $urandom_range(0, 3);
      wc   = $urandom_range(1, 40);
      bs   = $urandom_range(0, 3);
      io   = 1'($urandom_range(0, 1));
      s    = $urandom & 32'hFFFF_FFFC;
      d    = $urandom & 32'hFFFF_FFFC;
      if (t == 0) s = 32'hFFFF_FFF0;
      if (t == 1) d = 32'hFFFF_FFF8;
      build_exp(s, d, wc, io, bs);
      run_xfer(s, d, wc, io, bs, 3000, -1, cyc, fin);
      n = diff_ops();
      checks++;
      if (!fin || n != 0 || done_cnt != 1 ||
          xfer_count !== 32'(wc)) begin
        errors++;
        $display("FAIL random[%0d]: fin=%b diffs=%0d done=%0d xfer=%0d want %0d",
                 t, fin, n, done_cnt, xfer_count, wc);
      end
    end
  endtask

  task automatic test_reset_mid;
    int cyc; bit fin; int n; int k;
    bit seen;
    gmax = 0; rmax = 0;
    act_q.delete();
    done_cnt = 0; err_cnt = 0; rd_idx = 0; wr_idx = 0;
    @(negedge clk);
    src_addr = 32'h1100; dst_addr = 32'h2200;
    word_count = 15'd8; io_mem = 1'b0; burst_size = 2'd2;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    seen = 1'b0;
    k = 0;
    while (!seen && k < 100) begin
      if (state == 4'd3) seen = 1'b1;
      else begin @(negedge clk); k++; end
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL mid_reach: never saw write phase, state=%0d", state);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({mem_req, mem_we, busy, done, error, state, fifo_level,
         xfer_count, err_code, err_offset, mem_addr,
         mem_wdata} !== '0) begin
      errors++;
      $display("FAIL mid_reset: req=%b state=%0d lvl=%0d xfer=%0d want all 0",
               mem_req, state, fifo_level, xfer_count);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    checks++;
    if (done_cnt != 0 || err_cnt != 0) begin
      errors++;
      $display("FAIL mid_pulse: done=%0d err=%0d want 0 0",
               done_cnt, err_cnt);
    end
    build_exp(32'h1100, 32'h2200, 7, 1'b0, 2);
    run_xfer(32'h1100, 32'h2200, 7, 1'b0, 2, 300, -1, cyc, fin);
    n = diff_ops();
    checks++;
    if (!fin || n != 0 || done_cnt != 1 || xfer_count !== 32'd7) begin
      errors++;
      $display("FAIL mid_restart: fin=%b diffs=%0d done=%0d xfer=%0d",
               fin, n, done_cnt, xfer_count);
    end
  endtask

  task automatic test_stability;
    checks++;
    if (viol != 0) begin
      errors++;
      $display("FAIL req_stable: %0d unstable or overlapping requests, want 0",
               viol);
    end
  endtask

  initial begin
    inj_rd = -1; inj_wr = -1; gnt_block = 1'b0;
    gmax = 0; rmax = 0; viol = 0;
    test_reset;
    test_basic;
    test_io_mem;
    test_align;
    test_bus_err;
    test_timeout;
    test_busy_ignore;
    test_random;
    test_reset_mid;
    test_stability;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
